// File: rtl/itr_service_seq_if.sv
// Interface bundling the controller handshake and the CPU context/control
// signals of the interrupt service sequencer.
interface itr_service_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              i_pending;
    logic [ADDR_W-1:0] isr_vec;
    logic              instr_done;
    logic              reti;
    logic [ADDR_W-1:0] pc_in;
    logic [DATA_W-1:0] acc_in;
    logic [1:0]        flags_in;
    logic              itr_en;
    logic              itr_ack;
    logic              stall;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_val;
    logic              acc_load;
    logic [DATA_W-1:0] acc_val;
    logic [1:0]        flags_val;
    logic              in_isr;
    logic              isr_fault;

    modport slave (
        input  i_pending, isr_vec, instr_done, reti, pc_in, acc_in, flags_in,
        output itr_en, itr_ack, stall, pc_load, pc_val, acc_load, acc_val,
               flags_val, in_isr, isr_fault
    );

    modport master (
        output i_pending, isr_vec, instr_done, reti, pc_in, acc_in, flags_in,
        input  itr_en, itr_ack, stall, pc_load, pc_val, acc_load, acc_val,
               flags_val, in_isr, isr_fault
    );
endinterface

// File: rtl/itr_service_seq.sv
// CPU-side interrupt responder: enters an ISR at an instruction boundary,
// saves and restores PC/ACC/flags, and guards the ISR with a watchdog.
module itr_service_seq #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             clr,
    itr_service_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SAVE,
        VECTOR,
        SERVICE,
        RESTORE
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] saved_pc;
    logic [DATA_W-1:0] saved_acc;
    logic [1:0]        saved_flags;
    logic [ADDR_W-1:0] saved_vec;
    logic [CNT_W-1:0]  count_q;
    logic              fault_q;
    logic              fault_set;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (count_q == LIMIT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A return that coincides with the watchdog expiry is a clean return.
    always_comb begin
        state_d   = state_q;
        fault_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_pending) state_d = ARM;
            end
            ARM: begin
                if (!bus.i_pending)      state_d = IDLE;
                else if (bus.instr_done) state_d = SAVE;
            end
            SAVE:   state_d = VECTOR;
            VECTOR: state_d = SERVICE;
            SERVICE: begin
                if (bus.reti && bus.instr_done) begin
                    state_d = RESTORE;
                end else if (timeout_hit) begin
                    state_d   = RESTORE;
                    fault_set = 1'b1;
                end
            end
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            saved_pc    <= '0;
            saved_acc   <= '0;
            saved_flags <= '0;
            saved_vec   <= '0;
        end else if (state_q == SAVE) begin
            saved_pc    <= bus.pc_in;
            saved_acc   <= bus.acc_in;
            saved_flags <= bus.flags_in;
            saved_vec   <= bus.isr_vec;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else if (state_q == VECTOR) begin
            count_q <= '0;
        end else if (state_q == SERVICE && count_q != CNT_MAX) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    // Load values are forced to zero whenever their load strobe is low.
    always_comb begin
        bus.itr_en    = 1'b0;
        bus.itr_ack   = 1'b0;
        bus.stall     = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_val    = '0;
        bus.acc_load  = 1'b0;
        bus.acc_val   = '0;
        bus.flags_val = '0;
        bus.in_isr    = 1'b0;
        bus.isr_fault = fault_q;
        case (state_q)
            IDLE, ARM: bus.itr_en = 1'b1;
            SAVE:      bus.stall  = 1'b1;
            VECTOR: begin
                bus.stall   = 1'b1;
                bus.itr_ack = 1'b1;
                bus.pc_load = 1'b1;
                bus.pc_val  = saved_vec;
            end
            SERVICE: bus.in_isr = 1'b1;
            RESTORE: begin
                bus.stall     = 1'b1;
                bus.pc_load   = 1'b1;
                bus.pc_val    = saved_pc;
                bus.acc_load  = 1'b1;
                bus.acc_val   = saved_acc;
                bus.flags_val = saved_flags;
            end
            default: bus.itr_en = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_itr_service_seq.sv
// Self-checking bench for itr_service_seq: scoreboarded PC/ACC loads across
// entry/return, spurious requests, reset in service, back-to-back and watchdog.
module tb_itr_service_seq;
    logic clk;
    logic clr;

    itr_service_seq_if #(.ADDR_W(8), .DATA_W(8)) ifm ();
    itr_service_seq_if #(.ADDR_W(8), .DATA_W(8)) ift4 ();
    itr_service_seq_if #(.ADDR_W(8), .DATA_W(8)) ift0 ();

    itr_service_seq #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifm)
    );

    itr_service_seq #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut_t4 (
        .clk (clk),
        .clr (clr),
        .bus (ift4)
    );

    itr_service_seq #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(0)) dut_t0 (
        .clk (clk),
        .clr (clr),
        .bus (ift0)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] acc;
        logic [1:0] flags;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total;
    int   bad;
    int   ack_cnt;
    int   load_cnt;
    int   a0;
    int   l0;
    int   n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters on the main instance, sampled at the edge closing each cycle.
    always @(posedge clk) begin
        if (ifm.itr_ack) ack_cnt++;
        if (ifm.pc_load) load_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [7:0] vec, input logic [7:0] pc,
                               input logic [7:0] acc, input logic [1:0] fl);
        ifm.isr_vec   = vec;
        ifm.pc_in     = pc;
        ifm.acc_in    = acc;
        ifm.flags_in  = fl;
        ifm.i_pending = 1'b1;
        tick();
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: vec, acc: 8'h00, flags: 2'b00});
        tick();
        ifm.instr_done = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b1;
        tick();
        tick();
        total++;
        if ({ifm.itr_en, ifm.itr_ack, ifm.stall, ifm.pc_load, ifm.acc_load, ifm.in_isr, ifm.isr_fault} !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 1000000", {ifm.itr_en, ifm.itr_ack, ifm.stall, ifm.pc_load, ifm.acc_load, ifm.in_isr, ifm.isr_fault});
        end
        total++;
        if ({ifm.pc_val, ifm.acc_val, ifm.flags_val} !== 18'h0) begin
            bad++;
            $display("[TB] FAIL reset_vals: got %h want 0", {ifm.pc_val, ifm.acc_val, ifm.flags_val});
        end
        total++;
        if ({ift4.itr_en, ift0.itr_en, ift4.isr_fault} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL reset_aux: got %b want 110", {ift4.itr_en, ift0.itr_en, ift4.isr_fault});
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_entry_and_return;
        ifm.pc_in     = 8'h42;
        ifm.acc_in    = 8'h17;
        ifm.flags_in  = 2'b01;
        ifm.isr_vec   = 8'hB4;
        ifm.i_pending = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if ({ifm.itr_en, ifm.stall, ifm.pc_load} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL arm_wait: got %b want 100", {ifm.itr_en, ifm.stall, ifm.pc_load});
        end
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: 8'hB4, acc: 8'h00, flags: 2'b00});
        tick();
        ifm.instr_done = 1'b0;
        total++;
        if ({ifm.stall, ifm.itr_en, ifm.pc_load, ifm.itr_ack} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL save_state: got %b want 1000", {ifm.stall, ifm.itr_en, ifm.pc_load, ifm.itr_ack});
        end
        tick();
        e = sb.pop_front();
        total++;
        if ({ifm.pc_load, ifm.itr_ack, ifm.stall, ifm.acc_load, ifm.pc_val} !== {4'b1110, e.pc}) begin
            bad++;
            $display("[TB] FAIL vector_load: got %b/%h want 1110/%h", {ifm.pc_load, ifm.itr_ack, ifm.stall, ifm.acc_load}, ifm.pc_val, e.pc);
        end
        ifm.isr_vec   = 8'h99;
        ifm.i_pending = 1'b0;
        ifm.pc_in     = 8'hB4;
        ifm.acc_in    = 8'h55;
        ifm.flags_in  = 2'b10;
        tick();
        total++;
        if ({ifm.in_isr, ifm.itr_en, ifm.stall, ifm.pc_load, ifm.itr_ack} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL service_state: got %b want 10000", {ifm.in_isr, ifm.itr_en, ifm.stall, ifm.pc_load, ifm.itr_ack});
        end
        ifm.reti = 1'b1;
        tick();
        total++;
        if ({ifm.in_isr, ifm.pc_load} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL reti_no_done: got %b want 10", {ifm.in_isr, ifm.pc_load});
        end
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: 8'h42, acc: 8'h17, flags: 2'b01});
        tick();
        ifm.reti       = 1'b0;
        ifm.instr_done = 1'b0;
        e = sb.pop_front();
        total++;
        if ({ifm.pc_load, ifm.acc_load, ifm.stall, ifm.in_isr, ifm.pc_val, ifm.acc_val, ifm.flags_val} !== {4'b1110, e.pc, e.acc, e.flags}) begin
            bad++;
            $display("[TB] FAIL restore: got %b/%h/%h/%b want 1110/%h/%h/%b", {ifm.pc_load, ifm.acc_load, ifm.stall, ifm.in_isr}, ifm.pc_val, ifm.acc_val, ifm.flags_val, e.pc, e.acc, e.flags);
        end
        tick();
        total++;
        if ({ifm.itr_en, ifm.pc_load, ifm.acc_load, ifm.pc_val, ifm.acc_val, ifm.flags_val} !== 21'h100000) begin
            bad++;
            $display("[TB] FAIL back_idle: got %h want 100000", {ifm.itr_en, ifm.pc_load, ifm.acc_load, ifm.pc_val, ifm.acc_val, ifm.flags_val});
        end
    endtask

    task automatic test_spurious;
        a0 = ack_cnt;
        l0 = load_cnt;
        ifm.i_pending = 1'b1;
        tick();
        tick();
        tick();
        ifm.i_pending = 1'b0;
        tick();
        tick();
        total++;
        if ({ack_cnt - a0, load_cnt - l0} !== 64'd0) begin
            bad++;
            $display("[TB] FAIL spurious_pulses: got ack=%0d load=%0d want 0/0", ack_cnt - a0, load_cnt - l0);
        end
        total++;
        if ({ifm.itr_en, ifm.stall, ifm.in_isr} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL spurious_idle: got %b want 100", {ifm.itr_en, ifm.stall, ifm.in_isr});
        end
    endtask

    task automatic test_reti_ignored;
        l0 = load_cnt;
        ifm.reti       = 1'b1;
        ifm.instr_done = 1'b1;
        tick();
        tick();
        tick();
        ifm.reti       = 1'b0;
        ifm.instr_done = 1'b0;
        total++;
        if ({ifm.itr_en, ifm.in_isr, ifm.acc_load, ifm.stall} !== 4'b1000 || load_cnt != l0) begin
            bad++;
            $display("[TB] FAIL reti_idle: got %b loads=%0d want 1000 loads=0", {ifm.itr_en, ifm.in_isr, ifm.acc_load, ifm.stall}, load_cnt - l0);
        end
    endtask

    task automatic test_clear_in_service;
        drive_entry(8'h80, 8'h33, 8'h44, 2'b11);
        tick();
        e = sb.pop_front();
        total++;
        if (ifm.pc_val !== e.pc) begin
            bad++;
            $display("[TB] FAIL clr_vec: got %h want %h", ifm.pc_val, e.pc);
        end
        ifm.i_pending = 1'b0;
        tick();
        tick();
        #2;
        clr = 1'b1;
        #1;
        total++;
        if ({ifm.itr_en, ifm.in_isr, ifm.pc_load, ifm.acc_load, ifm.stall} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL clr_async: got %b want 10000", {ifm.itr_en, ifm.in_isr, ifm.pc_load, ifm.acc_load, ifm.stall});
        end
        l0 = load_cnt;
        tick();
        clr = 1'b0;
        tick();
        tick();
        total++;
        if (load_cnt != l0 || ifm.itr_en !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_no_restore: got loads=%0d en=%b want 0/1", load_cnt - l0, ifm.itr_en);
        end
        drive_entry(8'h90, 8'h10, 8'h20, 2'b10);
        tick();
        e = sb.pop_front();
        total++;
        if (ifm.pc_val !== e.pc) begin
            bad++;
            $display("[TB] FAIL clr_new_vec: got %h want %h", ifm.pc_val, e.pc);
        end
        ifm.i_pending = 1'b0;
        tick();
        ifm.reti       = 1'b1;
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: 8'h10, acc: 8'h20, flags: 2'b10});
        tick();
        ifm.reti       = 1'b0;
        ifm.instr_done = 1'b0;
        e = sb.pop_front();
        total++;
        if ({ifm.pc_val, ifm.acc_val, ifm.flags_val} !== {e.pc, e.acc, e.flags}) begin
            bad++;
            $display("[TB] FAIL clr_fresh_ctx: got %h/%h/%b want %h/%h/%b", ifm.pc_val, ifm.acc_val, ifm.flags_val, e.pc, e.acc, e.flags);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        a0 = ack_cnt;
        drive_entry(8'h30, 8'h50, 8'h05, 2'b00);
        tick();
        e = sb.pop_front();
        total++;
        if ({ifm.itr_ack, ifm.pc_val} !== {1'b1, e.pc}) begin
            bad++;
            $display("[TB] FAIL b2b_vec1: got %b/%h want 1/%h", ifm.itr_ack, ifm.pc_val, e.pc);
        end
        tick();
        total++;
        if ({ifm.itr_ack, ifm.in_isr} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL b2b_ack1_width: got %b want 01", {ifm.itr_ack, ifm.in_isr});
        end
        ifm.isr_vec    = 8'h60;
        ifm.pc_in      = 8'h31;
        ifm.reti       = 1'b1;
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: 8'h50, acc: 8'h05, flags: 2'b00});
        tick();
        ifm.reti       = 1'b0;
        ifm.instr_done = 1'b0;
        ifm.pc_in      = 8'h51;
        e = sb.pop_front();
        total++;
        if ({ifm.pc_load, ifm.pc_val, ifm.acc_val} !== {1'b1, e.pc, e.acc}) begin
            bad++;
            $display("[TB] FAIL b2b_restore: got %b/%h/%h want 1/%h/%h", ifm.pc_load, ifm.pc_val, ifm.acc_val, e.pc, e.acc);
        end
        tick();
        tick();
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: 8'h60, acc: 8'h00, flags: 2'b00});
        tick();
        ifm.instr_done = 1'b0;
        tick();
        e = sb.pop_front();
        total++;
        if ({ifm.itr_ack, ifm.pc_load, ifm.pc_val} !== {2'b11, e.pc}) begin
            bad++;
            $display("[TB] FAIL b2b_vec2: got %b/%h want 11/%h", {ifm.itr_ack, ifm.pc_load}, ifm.pc_val, e.pc);
        end
        ifm.i_pending = 1'b0;
        tick();
        total++;
        if (ifm.itr_ack !== 1'b0 || ack_cnt - a0 != 2) begin
            bad++;
            $display("[TB] FAIL b2b_ack_count: got ack=%b count=%0d want 0/2", ifm.itr_ack, ack_cnt - a0);
        end
        ifm.reti       = 1'b1;
        ifm.instr_done = 1'b1;
        sb.push_back('{pc: 8'h51, acc: 8'h05, flags: 2'b00});
        tick();
        ifm.reti       = 1'b0;
        ifm.instr_done = 1'b0;
        e = sb.pop_front();
        total++;
        if (ifm.pc_val !== e.pc) begin
            bad++;
            $display("[TB] FAIL b2b_restore2: got %h want %h", ifm.pc_val, e.pc);
        end
        tick();
    endtask

    task automatic test_watchdog;
        ift4.pc_in     = 8'h21;
        ift4.acc_in    = 8'h22;
        ift4.flags_in  = 2'b01;
        ift4.isr_vec   = 8'h70;
        for (int k = 0; k < 2; k++) begin
            ift4.i_pending = 1'b1;
            tick();
            ift4.instr_done = 1'b1;
            sb.push_back('{pc: 8'h70, acc: 8'h00, flags: 2'b00});
            tick();
            ift4.instr_done = 1'b0;
            tick();
            e = sb.pop_front();
            total++;
            if ({ift4.pc_load, ift4.pc_val} !== {1'b1, e.pc}) begin
                bad++;
                $display("[TB] FAIL wd_vec%0d: got %b/%h want 1/%h", k, ift4.pc_load, ift4.pc_val, e.pc);
            end
            ift4.i_pending = 1'b0;
            tick();
            sb.push_back('{pc: 8'h21, acc: 8'h22, flags: 2'b01});
            if (k == 0) begin
                tick();
                tick();
                tick();
                ift4.reti       = 1'b1;
                ift4.instr_done = 1'b1;
                tick();
                ift4.reti       = 1'b0;
                ift4.instr_done = 1'b0;
                e = sb.pop_front();
                total++;
                if ({ift4.pc_load, ift4.isr_fault, ift4.pc_val} !== {2'b10, e.pc}) begin
                    bad++;
                    $display("[TB] FAIL wd_reti_wins: got %b/%h want 10/%h", {ift4.pc_load, ift4.isr_fault}, ift4.pc_val, e.pc);
                end
            end else begin
                n = 0;
                while (ift4.in_isr && n < 20) begin
                    total++;
                    if (ift4.isr_fault !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL wd_early_fault: got %b want 0 at cycle %0d", ift4.isr_fault, n);
                    end
                    n++;
                    tick();
                end
                e = sb.pop_front();
                total++;
                if (n != 4 || {ift4.pc_load, ift4.isr_fault, ift4.pc_val, ift4.acc_val} !== {2'b11, e.pc, e.acc}) begin
                    bad++;
                    $display("[TB] FAIL wd_expire: got n=%0d %b/%h/%h want n=4 11/%h/%h", n, {ift4.pc_load, ift4.isr_fault}, ift4.pc_val, ift4.acc_val, e.pc, e.acc);
                end
            end
            tick();
        end
        tick();
        tick();
        total++;
        if ({ift4.isr_fault, ift4.itr_en} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL wd_sticky: got %b want 11", {ift4.isr_fault, ift4.itr_en});
        end
    endtask

    task automatic test_watchdog_disabled;
        ift0.pc_in     = 8'h0C;
        ift0.acc_in    = 8'hA5;
        ift0.flags_in  = 2'b11;
        ift0.isr_vec   = 8'hE0;
        ift0.i_pending = 1'b1;
        tick();
        ift0.instr_done = 1'b1;
        tick();
        ift0.instr_done = 1'b0;
        tick();
        ift0.i_pending = 1'b0;
        tick();
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!ift0.in_isr || ift0.isr_fault) n++;
            tick();
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("[TB] FAIL wd_disabled: got %0d bad cycles want 0", n);
        end
        ift0.reti       = 1'b1;
        ift0.instr_done = 1'b1;
        sb.push_back('{pc: 8'h0C, acc: 8'hA5, flags: 2'b11});
        tick();
        ift0.reti       = 1'b0;
        ift0.instr_done = 1'b0;
        e = sb.pop_front();
        total++;
        if ({ift0.pc_load, ift0.isr_fault, ift0.pc_val, ift0.acc_val, ift0.flags_val} !== {2'b10, e.pc, e.acc, e.flags}) begin
            bad++;
            $display("[TB] FAIL wd_disabled_ret: got %b/%h/%h/%b want 10/%h/%h/%b", {ift0.pc_load, ift0.isr_fault}, ift0.pc_val, ift0.acc_val, ift0.flags_val, e.pc, e.acc, e.flags);
        end
        tick();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        ack_cnt  = 0;
        load_cnt = 0;
        clr      = 1'b1;
        {ifm.i_pending, ifm.instr_done, ifm.reti}    = 3'b000;
        {ift4.i_pending, ift4.instr_done, ift4.reti} = 3'b000;
        {ift0.i_pending, ift0.instr_done, ift0.reti} = 3'b000;
        {ifm.isr_vec, ifm.pc_in, ifm.acc_in, ifm.flags_in}     = '0;
        {ift4.isr_vec, ift4.pc_in, ift4.acc_in, ift4.flags_in} = '0;
        {ift0.isr_vec, ift0.pc_in, ift0.acc_in, ift0.flags_in} = '0;
        test_reset();
        test_entry_and_return();
        test_spurious();
        test_reti_ignored();
        test_clear_in_service();
        test_back_to_back();
        test_watchdog();
        test_watchdog_disabled();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
